// File: rtl/ahb_apb_pkg.sv
// Shared types and constants for the AHB-to-APB bridge: transfer/response codes,
// error FSM states, one-hot slave selects and the default address map.
package ahb_apb_pkg;

   typedef enum logic [1:0] {
      HTRANS_IDLE   = 2'b00,
      HTRANS_BUSY   = 2'b01,
      HTRANS_NONSEQ = 2'b10,
      HTRANS_SEQ    = 2'b11
   } htrans_e;

   localparam logic [1:0] HRESP_OKAY  = 2'b00;
   localparam logic [1:0] HRESP_ERROR = 2'b01;

   typedef enum logic [1:0] {
      ERR_OKAY = 2'b00,
      ERR_ERR1 = 2'b01,
      ERR_ERR2 = 2'b10
   } err_state_e;

   localparam logic [2:0] SEL_NONE = 3'b000;
   localparam logic [2:0] SEL_S0   = 3'b001;
   localparam logic [2:0] SEL_S1   = 3'b010;
   localparam logic [2:0] SEL_S2   = 3'b100;

   localparam logic [31:0] DEF_BASE_ADDR   = 32'h8000_0000;
   localparam int          DEF_REGION_BITS = 26;

   // Only NONSEQ/SEQ phases on a ready bus carry a real transfer.
   function automatic logic is_active(input logic hreadyin, input logic [1:0] htrans);
      return hreadyin && ((htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ));
   endfunction

endpackage

// File: rtl/ahb_slave_interface_if.sv
// AHB-side bus bundle of the bridge front end; the master modport drives the
// AHB/APB inputs, the slave modport (the bridge) drives the qualified/delayed outputs.
interface ahb_slave_interface_if;
   logic        hwrite;
   logic        hreadyin;
   logic [1:0]  htrans;
   logic [31:0] haddr;
   logic [31:0] hwdata;
   logic [31:0] prdata;

   logic        valid;
   logic [2:0]  temp_selx;
   logic [31:0] haddr1;
   logic [31:0] haddr2;
   logic [31:0] hwdata1;
   logic [31:0] hwdata2;
   logic        hwrite_reg;
   logic        hwrite_reg1;
   logic [31:0] hrdata;
   logic [1:0]  hresp;
   logic        err_readyout;

   modport master (
      output hwrite, hreadyin, htrans, haddr, hwdata, prdata,
      input  valid, temp_selx, haddr1, haddr2, hwdata1, hwdata2,
             hwrite_reg, hwrite_reg1, hrdata, hresp, err_readyout
   );

   modport slave (
      input  hwrite, hreadyin, htrans, haddr, hwdata, prdata,
      output valid, temp_selx, haddr1, haddr2, hwdata1, hwdata2,
             hwrite_reg, hwrite_reg1, hrdata, hresp, err_readyout
   );
endinterface

// File: rtl/ahb_addr_decoder.sv
// Combinational address decode: haddr -> one-hot APB slave select and mapped flag.
// Zero latency, no state; addresses below the base wrap to a large index and read as unmapped.
module ahb_addr_decoder
   import ahb_apb_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR   = DEF_BASE_ADDR,
   parameter int          REGION_BITS = DEF_REGION_BITS
) (
   input  logic [31:0] i_haddr,
   output logic        o_mapped,
   output logic [2:0]  o_sel
);

   logic [31:0] w_offset;
   logic [31:0] w_index;

   assign w_offset = i_haddr - BASE_ADDR;
   assign w_index  = w_offset >> REGION_BITS;

   always_comb begin
      o_sel = SEL_NONE;
      case (w_index)
         32'd0:   o_sel = SEL_S0;
         32'd1:   o_sel = SEL_S1;
         32'd2:   o_sel = SEL_S2;
         default: o_sel = SEL_NONE;
      endcase
   end

   assign o_mapped = (o_sel != SEL_NONE);

endmodule

// File: rtl/ahb_slave_interface.sv
// AHB-Lite slave front end: zero-latency valid/select, 1- and 2-cycle address/data/direction
// delays, pass-through read data, and the two-cycle ERROR response (ERR1 pulls ready low).
module ahb_slave_interface
   import ahb_apb_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR   = DEF_BASE_ADDR,
   parameter int          REGION_BITS = DEF_REGION_BITS
) (
   input  logic                  hclk,
   input  logic                  hresetn,
   ahb_slave_interface_if.slave  bus
);

   logic        w_active;
   logic        w_mapped;
   logic [2:0]  w_sel;
   logic        w_err_hit;

   err_state_e  r_state;
   logic [1:0]  r_hresp;
   logic        r_err_readyout;

   logic [31:0] r_haddr1;
   logic [31:0] r_haddr2;
   logic [31:0] r_hwdata1;
   logic [31:0] r_hwdata2;
   logic        r_hwrite_reg;
   logic        r_hwrite_reg1;

   ahb_addr_decoder #(
      .BASE_ADDR   (BASE_ADDR),
      .REGION_BITS (REGION_BITS)
   ) u_addr_decoder (
      .i_haddr  (bus.haddr),
      .o_mapped (w_mapped),
      .o_sel    (w_sel)
   );

   assign w_active  = is_active(bus.hreadyin, bus.htrans);
   assign w_err_hit = w_active && !w_mapped;

   // Phases seen during ERR1 are never qualified; the bus is stalled there.
   assign bus.valid     = w_active && w_mapped && (r_state != ERR_ERR1);
   assign bus.temp_selx = w_sel;
   assign bus.hrdata    = bus.prdata;

   always_ff @(posedge hclk or negedge hresetn) begin
      if (!hresetn) begin
         r_haddr1      <= '0;
         r_haddr2      <= '0;
         r_hwdata1     <= '0;
         r_hwdata2     <= '0;
         r_hwrite_reg  <= 1'b0;
         r_hwrite_reg1 <= 1'b0;
      end else begin
         r_haddr1      <= bus.haddr;
         r_haddr2      <= r_haddr1;
         r_hwdata1     <= bus.hwdata;
         r_hwdata2     <= r_hwdata1;
         r_hwrite_reg  <= bus.hwrite;
         r_hwrite_reg1 <= r_hwrite_reg;
      end
   end

   always_ff @(posedge hclk or negedge hresetn) begin
      if (!hresetn) begin
         r_state        <= ERR_OKAY;
         r_hresp        <= HRESP_OKAY;
         r_err_readyout <= 1'b1;
      end else begin
         case (r_state)
            ERR_OKAY: begin
               if (w_err_hit) begin
                  r_state        <= ERR_ERR1;
                  r_hresp        <= HRESP_ERROR;
                  r_err_readyout <= 1'b0;
               end
            end
            ERR_ERR1: begin
               r_state        <= ERR_ERR2;
               r_hresp        <= HRESP_ERROR;
               r_err_readyout <= 1'b1;
            end
            ERR_ERR2: begin
               if (w_err_hit) begin
                  r_state        <= ERR_ERR1;
                  r_hresp        <= HRESP_ERROR;
                  r_err_readyout <= 1'b0;
               end else begin
                  r_state        <= ERR_OKAY;
                  r_hresp        <= HRESP_OKAY;
                  r_err_readyout <= 1'b1;
               end
            end
            default: begin
               r_state        <= ERR_OKAY;
               r_hresp        <= HRESP_OKAY;
               r_err_readyout <= 1'b1;
            end
         endcase
      end
   end

   assign bus.haddr1       = r_haddr1;
   assign bus.haddr2       = r_haddr2;
   assign bus.hwdata1      = r_hwdata1;
   assign bus.hwdata2      = r_hwdata2;
   assign bus.hwrite_reg   = r_hwrite_reg;
   assign bus.hwrite_reg1  = r_hwrite_reg1;
   assign bus.hresp        = r_hresp;
   assign bus.err_readyout = r_err_readyout;

endmodule

// File: tb/tb_ahb_slave_interface.sv
// Bench for ahb_slave_interface: directed literal checks plus randomized phases compared
// every cycle against an input-history / error-age reference model.
module tb_ahb_slave_interface;
   import ahb_apb_pkg::*;

   localparam logic [31:0] BASE = 32'h8000_0000;
   localparam int          RB   = 26;

   logic hclk = 1'b0;
   logic hresetn;

   ahb_slave_interface_if bus();

   ahb_slave_interface #(
      .BASE_ADDR   (BASE),
      .REGION_BITS (RB)
   ) dut (
      .hclk    (hclk),
      .hresetn (hresetn),
      .bus     (bus.slave)
   );

   always #5 hclk = ~hclk;

   int n_vec = 0;
   int n_err = 0;
   bit chk_en = 1'b0;

   typedef struct packed {
      logic [31:0] haddr;
      logic [31:0] hwdata;
      logic        hwrite;
   } rec_t;

   rec_t hist[$];      // hist[0] = inputs at the last edge, hist[1] = the edge before
   int   err_age = 0;  // edges since an unmapped phase was accepted (1 = ERR1, 2 = ERR2)
   rec_t m_rec;
   logic m_hit;
   logic [2:0] c_sel;

   function automatic logic [2:0] ref_sel(input logic [31:0] a);
      logic [31:0] k;
      k = (a - BASE) / (32'd1 << RB);
      if (k == 0) return 3'b001;
      if (k == 1) return 3'b010;
      if (k == 2) return 3'b100;
      return 3'b000;
   endfunction

   function automatic logic ref_active(input logic rdy, input logic [1:0] tr);
      return rdy && (tr >= 2'd2);
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
      n_vec++;
      if (act !== want) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, want, $time);
      end
   endtask

   always @(posedge hclk or negedge hresetn) begin
      if (!hresetn) begin
         hist.delete();
         hist.push_back('0);
         hist.push_back('0);
         err_age = 0;
      end else begin
         m_hit = ref_active(bus.hreadyin, bus.htrans) && (ref_sel(bus.haddr) == 3'b000)
                 && (err_age != 1);
         m_rec.haddr  = bus.haddr;
         m_rec.hwdata = bus.hwdata;
         m_rec.hwrite = bus.hwrite;
         hist.push_front(m_rec);
         void'(hist.pop_back());
         if (m_hit)             err_age = 1;
         else if (err_age == 1) err_age = 2;
         else                   err_age = 0;
      end
   end

   always @(negedge hclk) begin
      if (chk_en) begin
         c_sel = ref_sel(bus.haddr);
         chk("valid", 32'(bus.valid),
             32'(ref_active(bus.hreadyin, bus.htrans) && (c_sel != 3'b000) && (err_age != 1)));
         chk("temp_selx", 32'(bus.temp_selx), 32'(c_sel));
         chk("haddr1", bus.haddr1, hist[0].haddr);
         chk("haddr2", bus.haddr2, hist[1].haddr);
         chk("hwdata1", bus.hwdata1, hist[0].hwdata);
         chk("hwdata2", bus.hwdata2, hist[1].hwdata);
         chk("hwrite_reg", 32'(bus.hwrite_reg), 32'(hist[0].hwrite));
         chk("hwrite_reg1", 32'(bus.hwrite_reg1), 32'(hist[1].hwrite));
         chk("hrdata", bus.hrdata, bus.prdata);
         chk("hresp", 32'(bus.hresp), (err_age == 1 || err_age == 2) ? 32'd1 : 32'd0);
         chk("err_readyout", 32'(bus.err_readyout), (err_age == 1) ? 32'd0 : 32'd1);
      end
   end

   task automatic drive(input logic [1:0] tr, input logic rdy, input logic wr,
                        input logic [31:0] a, input logic [31:0] wd, input logic [31:0] pd);
      @(posedge hclk);
      #1;
      bus.htrans   = tr;
      bus.hreadyin = rdy;
      bus.hwrite   = wr;
      bus.haddr    = a;
      bus.hwdata   = wd;
      bus.prdata   = pd;
   endtask

   task automatic idle(input logic rdy);
      drive(2'b00, rdy, 1'b0, 32'h0, 32'h0, 32'h0);
   endtask

   logic [31:0] bd[4];
   logic [1:0]  q_tr[3];
   logic        q_rdy[3];
   logic [31:0] ra;

   initial begin
      hresetn      = 1'b0;
      bus.htrans   = 2'b00;
      bus.hreadyin = 1'b1;
      bus.hwrite   = 1'b0;
      bus.haddr    = 32'h0;
      bus.hwdata   = 32'h0;
      bus.prdata   = 32'h0;
      repeat (2) @(posedge hclk);
      chk_en = 1'b1;

      @(negedge hclk);
      chk("rst_hresp", 32'(bus.hresp), 32'd0);
      chk("rst_ready", 32'(bus.err_readyout), 32'd1);
      @(posedge hclk);
      #1 hresetn = 1'b1;

      // single NONSEQ write into slave 1
      drive(2'b10, 1'b1, 1'b1, 32'h8400_0010, 32'h0, 32'h0);
      @(negedge hclk);
      chk("wr_valid", 32'(bus.valid), 32'd1);
      chk("wr_sel", 32'(bus.temp_selx), 32'b010);
      drive(2'b00, 1'b1, 1'b0, 32'h0, 32'h1111_2222, 32'h0);
      @(negedge hclk);
      chk("wr_haddr1", bus.haddr1, 32'h8400_0010);
      chk("wr_hwrite_reg", 32'(bus.hwrite_reg), 32'd1);
      idle(1'b1);
      @(negedge hclk);
      chk("wr_haddr2", bus.haddr2, 32'h8400_0010);
      chk("wr_hwrite_reg1", 32'(bus.hwrite_reg1), 32'd1);

      // four-beat burst, data phases trail address phases by one cycle
      bd[0] = 32'hA0A0_0001; bd[1] = 32'hB1B1_0002; bd[2] = 32'hC2C2_0003; bd[3] = 32'hD3D3_0004;
      drive(2'b10, 1'b1, 1'b1, 32'h8000_0100, 32'h0, 32'h0);
      for (int c = 0; c < 6; c++) begin
         if (c < 4) drive((c < 3) ? 2'b11 : 2'b00, 1'b1, 1'b1, 32'h8000_0104 + 32'(4 * c), bd[c], 32'h0);
         else idle(1'b1);
         @(negedge hclk);
         if (c >= 1 && c <= 4) chk("burst_hwdata1", bus.hwdata1, bd[c - 1]);
         if (c >= 2) chk("burst_hwdata2", bus.hwdata2, bd[c - 2]);
      end

      // inactive phases at a mapped address
      q_tr[0] = 2'b00; q_tr[1] = 2'b01; q_tr[2] = 2'b10;
      q_rdy[0] = 1'b1; q_rdy[1] = 1'b1; q_rdy[2] = 1'b0;
      for (int i = 0; i < 3; i++) begin
         drive(q_tr[i], q_rdy[i], 1'b0, 32'h8000_0000, 32'h0, 32'h0);
         @(negedge hclk);
         chk("inact_valid", 32'(bus.valid), 32'd0);
         chk("inact_hresp", 32'(bus.hresp), 32'd0);
      end
      idle(1'b1);
      @(negedge hclk);
      chk("inact_ready", 32'(bus.err_readyout), 32'd1);

      // unmapped NONSEQ: ERR1, ERR2, OKAY
      drive(2'b10, 1'b1, 1'b0, 32'h8C00_0000, 32'h0, 32'h0);
      @(negedge hclk);
      chk("um_valid", 32'(bus.valid), 32'd0);
      chk("um_sel", 32'(bus.temp_selx), 32'd0);
      idle(1'b0);
      @(negedge hclk);
      chk("err1_resp", 32'(bus.hresp), 32'd1);
      chk("err1_ready", 32'(bus.err_readyout), 32'd0);
      idle(1'b1);
      @(negedge hclk);
      chk("err2_resp", 32'(bus.hresp), 32'd1);
      chk("err2_ready", 32'(bus.err_readyout), 32'd1);
      idle(1'b1);
      @(negedge hclk);
      chk("okay_resp", 32'(bus.hresp), 32'd0);

      // chained: second unmapped phase during ERR2 goes straight back to ERR1
      drive(2'b10, 1'b1, 1'b0, 32'h8C00_0000, 32'h0, 32'h0);
      idle(1'b0);
      drive(2'b10, 1'b1, 1'b0, 32'h9000_0000, 32'h0, 32'h0);
      @(negedge hclk);
      chk("chain_err2_ready", 32'(bus.err_readyout), 32'd1);
      idle(1'b0);
      @(negedge hclk);
      chk("chain_err1_resp", 32'(bus.hresp), 32'd1);
      chk("chain_err1_ready", 32'(bus.err_readyout), 32'd0);
      idle(1'b1);
      idle(1'b1);
      @(negedge hclk);
      chk("chain_okay", 32'(bus.hresp), 32'd0);

      // read data passes straight through
      drive(2'b10, 1'b1, 1'b0, 32'h8800_0000, 32'h0, 32'hDEAD_BEEF);
      @(negedge hclk);
      chk("rd_hrdata", bus.hrdata, 32'hDEAD_BEEF);
      chk("rd_sel", 32'(bus.temp_selx), 32'b100);

      // asynchronous reset in the middle of ERR1
      drive(2'b10, 1'b1, 1'b1, 32'h8C00_0040, 32'h5555_AAAA, 32'h0);
      @(posedge hclk);
      #2;
      chk("pre_rst_err1", 32'(bus.hresp), 32'd1);
      hresetn = 1'b0;
      #1;
      chk("mid_rst_hresp", 32'(bus.hresp), 32'd0);
      chk("mid_rst_ready", 32'(bus.err_readyout), 32'd1);
      chk("mid_rst_haddr1", bus.haddr1, 32'h0);
      chk("mid_rst_haddr2", bus.haddr2, 32'h0);
      chk("mid_rst_hwdata1", bus.hwdata1, 32'h0);
      chk("mid_rst_hwdata2", bus.hwdata2, 32'h0);
      chk("mid_rst_hwrite", 32'({bus.hwrite_reg, bus.hwrite_reg1}), 32'd0);
      @(posedge hclk);
      #1 hresetn = 1'b1;

      // randomized phases, checked every cycle by the model
      for (int i = 0; i < 400; i++) begin
         case ($urandom_range(0, 3))
            0:       ra = BASE + ($urandom % (32'd3 << RB));
            1:       ra = 32'h8C00_0000 + 32'($urandom_range(0, 32'h03FF_FFFF));
            2:       ra = 32'($urandom_range(0, 32'h7FFF_FFFF));
            default: ra = $urandom;
         endcase
         drive(2'($urandom_range(0, 3)), ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
               ra, $urandom, $urandom);
         if (i == 200) begin
            #2 hresetn = 1'b0;
            #5 hresetn = 1'b1;
         end
      end

      idle(1'b1);
      @(negedge hclk);
      chk_en = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/ahb_slave_interface.md
# ahb_slave_interface

AHB-Lite slave front end of the AHB-to-APB bridge: qualifies AHB address phases into a `valid` strobe, decodes the target APB slave, and delays address, write-data and direction by one and two cycles for the downstream APB controller. It also returns read data combinationally and runs the two-cycle AHB ERROR response for unmapped addresses. It sits between the AHB interconnect and the APB controller and holds no APB protocol state of its own.

## Interface
- `BASE_ADDR`, 32'h8000_0000, start of the bridge's mapped window
- `REGION_BITS`, 26, log2 of bytes per APB slave region (three contiguous regions)
- `hclk`  in  1  bridge clock, rising edge
- `hresetn`  in  1  reset, asynchronous, active-low
- `hwrite`  in  1  AHB direction, 1 = write
- `hreadyin`  in  1  AHB bus ready (previous transfer completing)
- `htrans`  in  2  AHB transfer type
- `haddr`  in  32  AHB address
- `hwdata`  in  32  AHB write data
- `prdata`  in  32  APB read data from the selected slave
- `valid`  out  1  combinational; current address phase is a mapped, active transfer
- `temp_selx`  out  3  combinational one-hot slave select decoded from `haddr`
- `haddr1`, `haddr2`  out  32  `haddr` delayed 1 / 2 cycles
- `hwdata1`, `hwdata2`  out  32  `hwdata` delayed 1 / 2 cycles
- `hwrite_reg`, `hwrite_reg1`  out  1  `hwrite` delayed 1 / 2 cycles
- `hrdata`  out  32  read data to AHB, equal to `prdata`
- `hresp`  out  2  registered AHB response, 2'b00 OKAY, 2'b01 ERROR
- `err_readyout`  out  1  registered ready contribution from the error path; the bridge top ANDs it with the controller's ready

## Operation
- Active transfer: `hreadyin`=1 and `htrans` is NONSEQ (2'b10) or SEQ (2'b11). IDLE (2'b00) and BUSY (2'b01) are never active.
- Decode: slave index k = (`haddr` − `BASE_ADDR`) >> `REGION_BITS`. Mapped when k ∈ {0,1,2}, giving `temp_selx` = 3'b001 / 3'b010 / 3'b100. When unmapped, `temp_selx` = 3'b000.
- `valid` = active & mapped & (err_state != ERR1).
- Pipelines are free-running and register every clock regardless of `hreadyin`:
  - `haddr1`←`haddr`, `haddr2`←`haddr1`
  - `hwdata1`←`hwdata`, `hwdata2`←`hwdata1`
  - `hwrite_reg`←`hwrite`, `hwrite_reg1`←`hwrite_reg`
- `hrdata` = `prdata`. No registering and no muxing.
- Error FSM states:
  - OKAY: `hresp`=00, `err_readyout`=1. Goes to ERR1 when a transfer is active and unmapped.
  - ERR1: `hresp`=01, `err_readyout`=0. Always goes to ERR2.
  - ERR2: `hresp`=01, `err_readyout`=1. Goes to ERR1 if another active unmapped phase is present, otherwise to OKAY.
- Mapped active phases in ERR2 assert `valid` normally. Address phases in ERR1 are ignored, because the bus holds `hreadyin` low.
- Reset (asynchronous, any cycle, including mid-error) sets:
  - all pipeline registers and `hwrite_reg*` to 0
  - FSM to OKAY, so `hresp`=00 and `err_readyout`=1
  - Combinational outputs follow their inputs during reset.

## Timing
- `valid` and `temp_selx` have zero latency: they are valid in the same cycle as the address phase.
- `*1` outputs lag by one edge and `*2` outputs by two. In the cycle after a write address phase, the data phase value appears on `hwdata` and `haddr1` holds its address.
- Error: unmapped active phase in cycle N gives `valid`=0 in cycle N. Then:
  - cycle N+1: ERR1
  - cycle N+2: ERR2
  - cycle N+3: OKAY, unless chained
- Back-to-back unmapped phases alternate ERR1/ERR2 with no OKAY cycle between them.
- Reset release: the first edge with `hresetn`=1 registers the current inputs.

## Structure
- Package `ahb_apb_pkg` holds:
  - HTRANS codes (IDLE, BUSY, NONSEQ, SEQ)
  - HRESP codes (OKAY, ERROR)
  - error FSM state enum
  - one-hot select constants
  - default `BASE_ADDR` and `REGION_BITS`
- Sub-module `ahb_addr_decoder`: combinational `haddr` → {mapped, `temp_selx`}. It is shared with future bridge variants.

## Test plan
- Reset mid-ERR1 with `hresetn` low asynchronously between edges → `hresp`=00 and `err_readyout`=1 immediately; all `*1`/`*2` outputs = 0.
- NONSEQ write, `haddr`=32'h8400_0010, `hreadyin`=1:
  - same cycle: `valid`=1, `temp_selx`=3'b010
  - next cycle: `haddr1`=32'h8400_0010, `hwrite_reg`=1
  - cycle after: `haddr2`=32'h8400_0010, `hwrite_reg1`=1
- Four-beat SEQ write burst with data D0..D3 → `hwdata1` shows D0..D3 on consecutive cycles one cycle behind `hwdata`; `hwdata2` shows them one further cycle behind.
- IDLE, BUSY, and NONSEQ with `hreadyin`=0, all at 32'h8000_0000 → `valid`=0 in each case, FSM stays OKAY.
- NONSEQ at 32'h8C00_0000 → `valid`=0 and `temp_selx`=0; ERR1 (01/0) then ERR2 (01/1) then OKAY. Repeat with a second unmapped phase in ERR2 → ERR1 follows immediately.
- Read with `prdata`=32'hDEAD_BEEF → `hrdata`=32'hDEAD_BEEF in the same cycle.
